// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the framebuffer line reader.
// The FSM state encoding and the default read-pipeline latency live here
// so the top and the testbench-facing documentation agree on them.
package fb_pkg;

    // Reader FSM states.
    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        FETCH,
        DONE
    } fb_rd_state_t;

    // Default framebuffer BRAM read latency in cycles.
    localparam int FB_RD_BRAM_LAT = 1;

    // Cycles from an address being issued to the linebuffer write appearing:
    // the BRAM latency plus the registered linebuffer output stage.
    localparam int FB_RD_PIPE_LAT = FB_RD_BRAM_LAT + 1;

endpackage

// File: rtl/fb_read_pipe.sv
// fb_read_pipe: shift register that carries the "read issued" valid bit and
// the matching linebuffer index alongside the BRAM read, so that they line
// up with fb_data when it comes back.
module fb_read_pipe #(
    parameter int STAGES = 1,
    parameter int XW     = 9
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,
    input  logic          in_valid,
    input  logic [XW-1:0] in_x,
    output logic          out_valid,
    output logic [XW-1:0] out_x,
    output logic          any_valid
);

    logic [STAGES-1:0] valid_q;
    logic [XW-1:0]     x_q [0:STAGES-1];

    // Shift valid and index one stage per clock.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; blocking here would collapse
    // the whole chain into a single stage.
    // NOTE: the index stages are reset along with the valid bits so a reset
    // mid-fetch leaves nothing in flight and the outputs start from zero.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            x_q[0]     <= in_x;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                x_q[i]     <= x_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_x     = x_q[STAGES-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/fb_line_reader.sv
// fb_line_reader: fetches one framebuffer row per FB_SCALE display lines
// from the bram_sdp read port into linebuffer_simple, with latency matching
// and overrun detection. Single clock domain (clk_sys).
// Optional feature: define FB_LINE_READER_STATS_EN to build the saturating
// overrun event counter on ovr_count; otherwise ovr_count is tied to 0.
module fb_line_reader
    import fb_pkg::*;
#(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int FB_SCALE  = 2,
    parameter int FB_OFFY   = 60,
    parameter int FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT),
    parameter int DATAW     = 8,
    parameter int BRAM_LAT  = FB_RD_BRAM_LAT
) (
    input  logic                        clk_sys,
    input  logic                        rst_sys_n,
    input  logic                        frame,
    input  logic                        line,
    input  logic signed [CORDW-1:0]     sy,
    output logic [FB_ADDRW-1:0]         fb_addr_read,
    input  logic [DATAW-1:0]            fb_data,
    output logic                        lb_we,
    output logic [$clog2(FB_WIDTH)-1:0] lb_x,
    output logic [DATAW-1:0]            lb_data,
    output logic                        busy,
    output logic                        overrun,
    output logic [7:0]                  ovr_count
);

    localparam int LBXW = $clog2(FB_WIDTH);
    localparam int ROWW = $clog2(FB_HEIGHT) + 1;
    localparam int SCW  = 6;
    // Issue register plus BRAM_LAT aligned stages, then the output register.
    localparam int PIPE_LAT = FB_RD_PIPE_LAT - FB_RD_BRAM_LAT + BRAM_LAT;
    localparam int PIPE_STAGES = PIPE_LAT - 1;

    // Display lines on which a line pulse may fetch; the row is shown on sy+1.
    localparam logic signed [CORDW-1:0] WIN_LO = CORDW'(FB_OFFY - 1);
    localparam logic signed [CORDW-1:0] WIN_HI = CORDW'(FB_OFFY + FB_HEIGHT*FB_SCALE - 2);

    fb_rd_state_t state, state_next;

    logic [LBXW-1:0]     cnt_x;
    logic [SCW-1:0]      cnt_scale;
    logic [ROWW-1:0]     row;
    logic [FB_ADDRW-1:0] row_base;

    logic            in_window;
    logic            last_x;
    logic            last_row;
    logic            fetch_issue;
    logic            start_fetch;
    logic            scale_adv;
    logic            line_ovr;

    logic            issue_valid;
    logic [LBXW-1:0] issue_x;
    logic            pipe_valid;
    logic [LBXW-1:0] pipe_x;
    logic            pipe_any;

    assign in_window = line && (sy >= WIN_LO) && (sy <= WIN_HI);
    assign last_x    = (cnt_x == LBXW'(FB_WIDTH - 1));
    assign last_row  = (row == ROWW'(FB_HEIGHT - 1));

    // State register.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; frame restarts the sequence from any state.
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (frame) begin
            state_next = WAIT_LINE;
        end else begin
            case (state)
                WAIT_LINE: if (in_window && cnt_scale == '0) state_next = FETCH;
                FETCH:     if (last_x) state_next = last_row ? DONE : WAIT_LINE;
                default:   state_next = state;
            endcase
        end
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        fetch_issue = 1'b0;
        start_fetch = 1'b0;
        scale_adv   = 1'b0;
        line_ovr    = 1'b0;
        if (!frame) begin
            case (state)
                WAIT_LINE: begin
                    scale_adv   = in_window;
                    start_fetch = in_window && (cnt_scale == '0);
                end
                FETCH: begin
                    fetch_issue = 1'b1;
                    scale_adv   = in_window;
                    line_ovr    = line;
                end
                default: ;
            endcase
        end
    end

    // Row, column and scale counters, read address and the sticky overrun flag.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            cnt_x        <= '0;
            cnt_scale    <= '0;
            row          <= '0;
            row_base     <= '0;
            fb_addr_read <= '0;
            overrun      <= 1'b0;
        end else if (frame) begin
            cnt_x        <= '0;
            cnt_scale    <= '0;
            row          <= '0;
            row_base     <= '0;
            fb_addr_read <= '0;
            overrun      <= 1'b0;
        end else begin
            if (scale_adv) begin
                cnt_scale <= (cnt_scale == SCW'(FB_SCALE - 1)) ? '0 : cnt_scale + 1'b1;
            end
            if (start_fetch) begin
                cnt_x <= '0;
            end
            if (fetch_issue) begin
                fb_addr_read <= row_base + FB_ADDRW'(cnt_x);
                if (last_x) begin
                    cnt_x    <= '0;
                    row_base <= row_base + FB_ADDRW'(FB_WIDTH);
                    row      <= row + 1'b1;
                end else begin
                    cnt_x <= cnt_x + 1'b1;
                end
            end
            if (line_ovr) begin
                overrun <= 1'b1;
            end
        end
    end

    // Mark which cycles carry a real read, in step with fb_addr_read.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            issue_valid <= 1'b0;
            issue_x     <= '0;
        end else begin
            issue_valid <= fetch_issue;
            issue_x     <= cnt_x;
        end
    end

    fb_read_pipe #(
        .STAGES (PIPE_STAGES),
        .XW     (LBXW)
    ) u_read_pipe (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .in_valid  (issue_valid),
        .in_x      (issue_x),
        .out_valid (pipe_valid),
        .out_x     (pipe_x),
        .any_valid (pipe_any)
    );

    // Register the returning read data into the linebuffer write port.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            lb_we   <= 1'b0;
            lb_x    <= '0;
            lb_data <= '0;
        end else begin
            lb_we <= pipe_valid;
            if (pipe_valid) begin
                lb_x    <= pipe_x;
                lb_data <= fb_data;
            end
        end
    end

    assign busy = (state == FETCH) || issue_valid || pipe_any;

`ifdef FB_LINE_READER_STATS_EN
    logic [7:0] ovr_count_q;

    // Count overrun events, saturating; frame does not clear it.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ovr_count_q <= '0;
        end else if (line_ovr && ovr_count_q != 8'hFF) begin
            ovr_count_q <= ovr_count_q + 1'b1;
        end
    end

    assign ovr_count = ovr_count_q;
`else
    assign ovr_count = '0;
`endif

endmodule
